// File: rtl/secure_router_collector.sv
//==============================================================================
// Module   : secure_router_collector
// Purpose  : Deserializes four strobed serial lanes and merges the words into
//            one lane-tagged valid/ready stream with round-robin arbitration.
//            Optional macro PARITY_EN adds an even-parity bit per word.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module secure_router_collector #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in0,
  input  logic              data_in1,
  input  logic              data_in2,
  input  logic              data_in3,
  input  logic              strobe_in0,
  input  logic              strobe_in1,
  input  logic              strobe_in2,
  input  logic              strobe_in3,
  input  logic              out_ready,
  input  logic              err_clr,
  output logic              out_valid,
  output logic [1:0]        out_lane,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        frame_err,
`ifdef PARITY_EN
  output logic [3:0]        parity_err,
`endif
  output logic [3:0]        ovf_err
);

`ifdef PARITY_EN
  localparam int c_WORD_LEN = DATA_W + 1;
`else
  localparam int c_WORD_LEN = DATA_W;
`endif
  // The shift register only keeps the bits that precede the current one.
  localparam int c_SHIFT_W = c_WORD_LEN - 1;
  localparam int c_CNT_W   = $clog2(c_WORD_LEN);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_WORD_LEN - 1);

  logic [3:0]          w_data;
  logic [3:0]          w_strobe;
  logic [3:0]          w_hold_vld;
  logic [4*DATA_W-1:0] w_hold_flat;
  logic [3:0]          w_grant;
  logic [1:0]          w_gnt_lane;
  logic                w_gnt_any;
  logic [1:0]          w_idx;
  logic                w_out_free;

  logic                r_out_valid;
  logic [1:0]          r_out_lane;
  logic [DATA_W-1:0]   r_out_data;
  logic [1:0]          r_ptr;

  assign w_data   = {data_in3, data_in2, data_in1, data_in0};
  assign w_strobe = {strobe_in3, strobe_in2, strobe_in1, strobe_in0};

  for (genvar n = 0; n < 4; n++) begin : g_lane
    logic [c_SHIFT_W-1:0] r_shift;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]    r_hold;
    logic                 r_hold_vld;
    logic                 r_frame_err;
    logic                 r_ovf_err;
    logic                 w_last;
    logic                 w_ok;
    logic                 w_done;
    logic                 w_frame_set;
    logic                 w_ovf_set;
    logic [DATA_W-1:0]    w_word;

    assign w_last = w_strobe[n] && (r_cnt == c_LAST);
`ifdef PARITY_EN
    logic r_parity_err;
    logic w_par_set;
    // Payload already sits in the shift register; the live bit is parity.
    assign w_word    = r_shift;
    assign w_ok      = ~^{r_shift, w_data[n]};
    assign w_par_set = w_last && !w_ok;
    assign parity_err[n] = r_parity_err;
`else
    assign w_word = {r_shift, w_data[n]};
    assign w_ok   = 1'b1;
`endif
    assign w_done      = w_last && w_ok;
    assign w_frame_set = !w_strobe[n] && (r_cnt != '0);
    assign w_ovf_set   = w_done && r_hold_vld && !w_grant[n];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_shift     <= '0;
        r_cnt       <= '0;
        r_hold      <= '0;
        r_hold_vld  <= 1'b0;
        r_frame_err <= 1'b0;
        r_ovf_err   <= 1'b0;
`ifdef PARITY_EN
        r_parity_err <= 1'b0;
`endif
      end else begin
        if (w_strobe[n]) begin
          r_shift <= c_SHIFT_W'({r_shift, w_data[n]});
          r_cnt   <= w_last ? '0 : r_cnt + c_CNT_W'(1);
        end else begin
          r_cnt <= '0;
        end
        // A grant in the same cycle frees the slot for the new word.
        if (w_done && (!r_hold_vld || w_grant[n])) begin
          r_hold     <= w_word;
          r_hold_vld <= 1'b1;
        end else if (w_grant[n]) begin
          r_hold_vld <= 1'b0;
        end
        r_frame_err <= w_frame_set | (r_frame_err & ~err_clr);
        r_ovf_err   <= w_ovf_set   | (r_ovf_err   & ~err_clr);
`ifdef PARITY_EN
        r_parity_err <= w_par_set | (r_parity_err & ~err_clr);
`endif
      end
    end

    assign w_hold_vld[n]                    = r_hold_vld;
    assign w_hold_flat[n*DATA_W +: DATA_W]  = r_hold;
    assign frame_err[n]                     = r_frame_err;
    assign ovf_err[n]                       = r_ovf_err;
  end

  assign w_out_free = !r_out_valid || out_ready;

  always_comb begin
    w_grant    = '0;
    w_gnt_lane = '0;
    w_gnt_any  = 1'b0;
    w_idx      = '0;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (w_out_free && !w_gnt_any && w_hold_vld[w_idx]) begin
        w_gnt_any        = 1'b1;
        w_gnt_lane       = w_idx;
        w_grant[w_idx]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_lane  <= '0;
      r_out_data  <= '0;
      r_ptr       <= '0;
    end else if (w_out_free) begin
      if (w_gnt_any) begin
        r_out_valid <= 1'b1;
        r_out_lane  <= w_gnt_lane;
        r_out_data  <= w_hold_flat[w_gnt_lane*DATA_W +: DATA_W];
        r_ptr       <= w_gnt_lane + 2'd1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_lane  = r_out_lane;
  assign out_data  = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_secure_router_collector.sv
// Testbench for secure_router_collector: directed scenarios plus a randomized
// run compared cycle by cycle against a word-level reference model.
`default_nettype none

module tb_secure_router_collector;

  localparam int DATA_W = 4;
`ifdef PARITY_EN
  localparam int WL = DATA_W + 1;
`else
  localparam int WL = DATA_W;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        data_v;
  logic [3:0]        strobe_v;
  logic              out_ready;
  logic              err_clr;
  logic              out_valid;
  logic [1:0]        out_lane;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        frame_err;
  logic [3:0]        ovf_err;
`ifdef PARITY_EN
  logic [3:0]        parity_err;
`endif

  int checks = 0;
  int errors = 0;

  secure_router_collector #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in0   (data_v[0]),
    .data_in1   (data_v[1]),
    .data_in2   (data_v[2]),
    .data_in3   (data_v[3]),
    .strobe_in0 (strobe_v[0]),
    .strobe_in1 (strobe_v[1]),
    .strobe_in2 (strobe_v[2]),
    .strobe_in3 (strobe_v[3]),
    .out_ready  (out_ready),
    .err_clr    (err_clr),
    .out_valid  (out_valid),
    .out_lane   (out_lane),
    .out_data   (out_data),
    .frame_err  (frame_err),
`ifdef PARITY_EN
    .parity_err (parity_err),
`endif
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: per-lane bit counts/accumulators, one-word hold slots,
  // and an output register fed by a rotating-priority search.
  int                m_cnt  [4];
  int                m_acc  [4];
  logic [DATA_W-1:0] m_hold [4];
  bit                m_hvld [4];
  bit                m_ov;
  int                m_lane;
  logic [DATA_W-1:0] m_data;
  int                m_ptr;
  logic [3:0]        m_ferr, m_oerr, m_perr;

  function automatic void model_reset();
    for (int l = 0; l < 4; l++) begin
      m_cnt[l] = 0; m_acc[l] = 0; m_hold[l] = '0; m_hvld[l] = 0;
    end
    m_ov = 0; m_lane = 0; m_data = '0; m_ptr = 0;
    m_ferr = '0; m_oerr = '0; m_perr = '0;
  endfunction

  function automatic void model_step();
    bit                free;
    int                g;
    int                l;
    int                payload;
    bit                ok;
    logic [3:0]        fset, oset, pset;
    logic [DATA_W-1:0] nhold [4];
    bit                nvld  [4];
    free = !m_ov || out_ready;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      l = (m_ptr + k) % 4;
      if (free && g < 0 && m_hvld[l]) g = l;
    end
    fset = '0; oset = '0; pset = '0;
    for (int n = 0; n < 4; n++) begin
      nhold[n] = m_hold[n];
      nvld[n]  = m_hvld[n] && (g != n);
      if (strobe_v[n]) begin
        m_acc[n] = (m_acc[n] << 1) | int'(data_v[n]);
        m_cnt[n] = m_cnt[n] + 1;
        if (m_cnt[n] == WL) begin
`ifdef PARITY_EN
          payload = (m_acc[n] >> 1) & ((1 << DATA_W) - 1);
          ok = (($countones(payload) % 2) == (m_acc[n] & 1));
`else
          payload = m_acc[n] & ((1 << DATA_W) - 1);
          ok = 1;
`endif
          if (!ok) pset[n] = 1'b1;
          else if (!m_hvld[n] || g == n) begin
            nhold[n] = DATA_W'(payload);
            nvld[n]  = 1;
          end else oset[n] = 1'b1;
          m_cnt[n] = 0;
          m_acc[n] = 0;
        end
      end else if (m_cnt[n] != 0) begin
        m_cnt[n] = 0;
        m_acc[n] = 0;
        fset[n]  = 1'b1;
      end
    end
    if (free) begin
      if (g >= 0) begin
        m_ov = 1; m_lane = g; m_data = m_hold[g]; m_ptr = (g + 1) % 4;
      end else m_ov = 0;
    end
    for (int n = 0; n < 4; n++) begin
      m_hold[n] = nhold[n];
      m_hvld[n] = nvld[n];
    end
    m_ferr = (err_clr ? 4'b0 : m_ferr) | fset;
    m_oerr = (err_clr ? 4'b0 : m_oerr) | oset;
    m_perr = (err_clr ? 4'b0 : m_perr) | pset;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  function automatic logic [WL-1:0] enc(input logic [DATA_W-1:0] w);
`ifdef PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  task automatic send_bits(input int lane, input logic [WL-1:0] bits);
    for (int b = WL - 1; b >= 0; b--) begin
      strobe_v[lane] = 1'b1;
      data_v[lane]   = bits[b];
      tick();
    end
    strobe_v[lane] = 1'b0;
    data_v[lane]   = 1'b0;
  endtask

  task automatic send_all(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                          input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3,
                          input logic [3:0] mask);
    logic [WL-1:0] bits [4];
    bits[0] = enc(w0); bits[1] = enc(w1); bits[2] = enc(w2); bits[3] = enc(w3);
    for (int b = WL - 1; b >= 0; b--) begin
      for (int l = 0; l < 4; l++) begin
        strobe_v[l] = mask[l];
        data_v[l]   = mask[l] & bits[l][b];
      end
      tick();
    end
    strobe_v = '0;
    data_v   = '0;
  endtask

  task automatic do_reset();
    strobe_v = '0; data_v = '0; err_clr = 1'b0; out_ready = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_lane !== 2'd0 || out_data !== '0 ||
        frame_err !== 4'd0 || ovf_err !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b lane=%0d data=%h ferr=%b oerr=%b, want all 0",
               out_valid, out_lane, out_data, frame_err, ovf_err);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid cycle %0d: got %b want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    send_bits(2, enc(4'hB));
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: valid=%b want 0 at last-bit edge", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_lane !== 2'd2 || out_data !== 4'hB) begin
      errors++;
      $display("FAIL single_word: valid=%b lane=%0d data=%h want 1/2/b", out_valid, out_lane, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || frame_err !== 4'd0 || ovf_err !== 4'd0) begin
      errors++;
      $display("FAIL single_after: valid=%b ferr=%b oerr=%b want 0/0/0", out_valid, frame_err, ovf_err);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    send_all(4'h1, 4'h2, 4'h3, 4'h4, 4'hF);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_lane !== 2'(i) || out_data !== DATA_W'(i + 1)) begin
        errors++;
        $display("FAIL rr_order %0d: valid=%b lane=%0d data=%h want 1/%0d/%0h",
                 i, out_valid, out_lane, out_data, i, i + 1);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain: valid=%b want 0", out_valid);
    end
    // Pointer has wrapped to lane 0, so lane 0 beats lane 3.
    send_all(4'h6, 4'h0, 4'h0, 4'h7, 4'b1001);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_data !== 4'h6) begin
      errors++;
      $display("FAIL rr_ptr_first: lane=%0d data=%h want 0/6", out_lane, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_lane !== 2'd3 || out_data !== 4'h7) begin
      errors++;
      $display("FAIL rr_ptr_second: lane=%0d data=%h want 3/7", out_lane, out_data);
    end
    tick();
  endtask

  task automatic test_frame_error();
    out_ready = 1'b1;
    strobe_v[1] = 1'b1; data_v[1] = 1'b1; tick();
    data_v[1] = 1'b0; tick();
    strobe_v[1] = 1'b0;
    tick();
    checks++;
    if (frame_err !== 4'b0010) begin
      errors++;
      $display("FAIL frame_set: got %b want 0010", frame_err);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL frame_no_output: valid=%b want 0", out_valid);
      end
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++;
    if (frame_err !== 4'b0000) begin
      errors++;
      $display("FAIL frame_clear: got %b want 0000", frame_err);
    end
  endtask

  task automatic test_err_priority();
    strobe_v[1] = 1'b1; data_v[1] = 1'b0; tick();
    strobe_v[1] = 1'b0; err_clr = 1'b1; tick();
    checks++;
    if (frame_err !== 4'b0010) begin
      errors++;
      $display("FAIL set_wins: got %b want 0010", frame_err);
    end
    tick(); err_clr = 1'b0;
    checks++;
    if (frame_err !== 4'b0000) begin
      errors++;
      $display("FAIL set_wins_clear: got %b want 0000", frame_err);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send_bits(3, enc(4'hA));
    send_bits(3, enc(4'h5));
    send_bits(3, enc(4'hC));
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_lane !== 2'd3 || out_data !== 4'hA || ovf_err !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_stall: valid=%b lane=%0d data=%h oerr=%b want 1/3/a/1000",
               out_valid, out_lane, out_data, ovf_err);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_lane !== 2'd3 || out_data !== 4'h5) begin
      errors++;
      $display("FAIL b2b_second: valid=%b lane=%0d data=%h want 1/3/5", out_valid, out_lane, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: valid=%b data=%h want 0", out_valid, out_data);
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    do_reset();
    send_bits(0, {4'hC, 1'b0});
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_data !== 4'hC || parity_err !== 4'd0) begin
      errors++;
      $display("FAIL parity_good: valid=%b data=%h perr=%b want 1/c/0000", out_valid, out_data, parity_err);
    end
    send_bits(0, {4'hC, 1'b1});
    tick();
    checks++;
    if (out_valid !== 1'b0 || parity_err !== 4'b0001) begin
      errors++;
      $display("FAIL parity_bad: valid=%b perr=%b want 0/0001", out_valid, parity_err);
    end
  endtask
`endif

  task automatic test_random();
    int shown = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int l = 0; l < 4; l++) begin
        strobe_v[l] = ($urandom_range(0, 9) != 0);
        data_v[l]   = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 40) == 0);
      tick();
      checks++;
      if (out_valid !== m_ov || (m_ov && (out_lane !== 2'(m_lane) || out_data !== m_data)) ||
          frame_err !== m_ferr || ovf_err !== m_oerr
`ifdef PARITY_EN
          || parity_err !== m_perr
`endif
          ) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cycle %0d: valid=%b lane=%0d data=%h ferr=%b oerr=%b, want %b/%0d/%h/%b/%b",
                   c, out_valid, out_lane, out_data, frame_err, ovf_err,
                   m_ov, m_lane, m_data, m_ferr, m_oerr);
        end
      end
    end
    strobe_v = '0; err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; strobe_v = '0; data_v = '0; out_ready = 1'b1; err_clr = 1'b0;
    test_reset();
    test_single_word();
    test_round_robin();
    test_frame_error();
    test_err_priority();
    test_back_to_back();
`ifdef PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
